pt2262_tx_ctrl: RTL and testbench

Frame sequencer for the PT2262-compatible encoder. It owns the bidirectional shift register: it parallel-loads the code word, reads the current trit from the register's two MSBs, and advances the register by two bits per trit using the 2-bit insert-left operation. It generates the PT2262 on-air waveform (12 trits plus sync) for a programmable number of back-to-back frames. It sits between the host command interface and the RF modulator.

---
 rtl/pt2262_tx_ctrl_if.sv | 28 ++
 rtl/pt2262_tx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pt2262_tx_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pt2262_tx_ctrl_if.sv
// Bus between the PT2262 frame sequencer, its host command side and the
// bidirectional shift register it owns.
interface pt2262_tx_ctrl_if #(
    parameter int TRITS = 12
);
    logic                 start;
    logic [2*TRITS-1:0]   code;
    logic                 stop;
    logic                 busy;
    logic                 done;
    logic                 dout;
    logic [2:0]           sr_op;
    logic [2*TRITS-1:0]   sr_d;
    logic [1:0]           sr_pt_bit;
    logic [2*TRITS-1:0]   sr_q;

    // Host and shift-register side of the sequencer.
    modport master (
        output start, code, stop, sr_q,
        input  busy, done, dout, sr_op, sr_d, sr_pt_bit
    );

    // The sequencer itself.
    modport slave (
        input  start, code, stop, sr_q,
        output busy, done, dout, sr_op, sr_d, sr_pt_bit
    );
endinterface

// File: rtl/pt2262_tx_ctrl.sv
// PT2262 frame sequencer: loads the code word into the external shift
// register, walks it two bits per trit and emits the on-air waveform
// (TRITS trits of 32 alpha plus a 128 alpha sync) for up to REPEAT frames.
module pt2262_tx_ctrl #(
    parameter int TRITS     = 12,
    parameter int ALPHA_CYC = 4,
    parameter int REPEAT    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pt2262_tx_ctrl_if.slave  bus
);
    localparam int W  = 2 * TRITS;
    localparam int PW = (ALPHA_CYC > 1) ? $clog2(ALPHA_CYC) : 1;
    localparam int TW = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam int FW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [PW-1:0] PRESC_LAST      = PW'(ALPHA_CYC - 1);
    localparam logic [TW-1:0] TRIT_LAST       = TW'(TRITS - 1);
    localparam logic [FW-1:0] FRAME_LAST      = FW'(REPEAT - 1);
    localparam logic [6:0]    TRIT_ALPHA_LAST = 7'd31;
    localparam logic [6:0]    SYNC_ALPHA_LAST = 7'd127;
    localparam logic [6:0]    SYNC_HIGH_LEN   = 7'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_TRIT = 2'd2;
    localparam logic [1:0] ST_SYNC = 2'd3;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SHL2 = 3'b100;

    // Registered state
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [6:0]    acnt;
    logic [TW-1:0] trit_idx;
    logic [FW-1:0] frame_cnt;
    logic          stop_seen;
    logic [W-1:0]  code_q;
    logic          busy_q;
    logic          done_q;
    logic          dout_q;

    // Next-state values
    logic [1:0]    nxt_state;
    logic [PW-1:0] nxt_presc;
    logic [6:0]    nxt_acnt;
    logic [TW-1:0] nxt_trit_idx;
    logic [FW-1:0] nxt_frame_cnt;
    logic [2:0]    sr_op_c;
    logic          done_c;
    logic          alpha_end;
    logic [1:0]    nxt_trit_sym;
    logic          dout_c;

    // Register contents after a 2-bit insert-left; its top pair is the
    // trit that becomes current once the shift takes effect.
    logic [W-1:0]  sr_shl;
    logic          sr_tail_unused;

    assign sr_shl         = bus.sr_q << 2;
    assign sr_tail_unused = ^sr_shl[W-3:0];

    // Level of a trit at alpha position a (0..31). Each half of the trit
    // is a 16 alpha pulse: narrow (4 high, 12 low) or wide (12 high, 4 low).
    // '0' is narrow/narrow, '1' wide/wide, 'f' narrow/wide.
    function automatic logic trit_level(input logic [1:0] trit, input logic [4:0] a);
        logic wide;
        if (a[4])
            wide = (trit != 2'b00);
        else
            wide = (trit == 2'b11);
        return wide ? (a[3:0] < 4'd12) : (a[3:0] < 4'd4);
    endfunction

    // Sequencer next-state, counter advance and shift-register command.
    always_comb begin
        alpha_end     = (presc == PRESC_LAST);
        nxt_state     = state;
        nxt_presc     = presc;
        nxt_acnt      = acnt;
        nxt_trit_idx  = trit_idx;
        nxt_frame_cnt = frame_cnt;
        sr_op_c       = OP_HOLD;
        done_c        = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt_presc    = '0;
                nxt_acnt     = '0;
                nxt_trit_idx = '0;
                if (bus.start) begin
                    nxt_state     = ST_LOAD;
                    nxt_frame_cnt = '0;
                end
            end
            ST_LOAD: begin
                sr_op_c      = OP_LOAD;
                nxt_state    = ST_TRIT;
                nxt_presc    = '0;
                nxt_acnt     = '0;
                nxt_trit_idx = '0;
            end
            ST_TRIT: begin
                nxt_presc = alpha_end ? '0 : presc + 1'b1;
                if (alpha_end) begin
                    if (acnt == TRIT_ALPHA_LAST) begin
                        sr_op_c  = OP_SHL2;
                        nxt_acnt = '0;
                        if (trit_idx == TRIT_LAST) begin
                            nxt_state    = ST_SYNC;
                            nxt_trit_idx = '0;
                        end else begin
                            nxt_trit_idx = trit_idx + 1'b1;
                        end
                    end else begin
                        nxt_acnt = acnt + 7'd1;
                    end
                end
            end
            ST_SYNC: begin
                nxt_presc = alpha_end ? '0 : presc + 1'b1;
                if (alpha_end) begin
                    if (acnt == SYNC_ALPHA_LAST) begin
                        nxt_acnt = '0;
                        // Back-to-back frame: reload the word, no idle gap.
                        if (frame_cnt != FRAME_LAST && !stop_seen && !bus.stop) begin
                            sr_op_c       = OP_LOAD;
                            nxt_state     = ST_TRIT;
                            nxt_frame_cnt = frame_cnt + 1'b1;
                        end else begin
                            nxt_state     = ST_IDLE;
                            nxt_frame_cnt = '0;
                            done_c        = 1'b1;
                        end
                    end else begin
                        nxt_acnt = acnt + 7'd1;
                    end
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // Look ahead to next cycle's waveform level so dout can be a flop.
    always_comb begin
        case (sr_op_c)
            OP_LOAD: nxt_trit_sym = code_q[W-1 -: 2];
            OP_SHL2: nxt_trit_sym = sr_shl[W-1 -: 2];
            default: nxt_trit_sym = bus.sr_q[W-1 -: 2];
        endcase
        case (nxt_state)
            ST_TRIT: dout_c = trit_level(nxt_trit_sym, nxt_acnt[4:0]);
            ST_SYNC: dout_c = (nxt_acnt < SYNC_HIGH_LEN);
            default: dout_c = 1'b0;
        endcase
    end

    // State, counters, sticky stop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            acnt      <= '0;
            trit_idx  <= '0;
            frame_cnt <= '0;
            stop_seen <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            state     <= nxt_state;
            presc     <= nxt_presc;
            acnt      <= nxt_acnt;
            trit_idx  <= nxt_trit_idx;
            frame_cnt <= nxt_frame_cnt;
            if (state == ST_IDLE)
                stop_seen <= 1'b0;
            else if (bus.stop)
                stop_seen <= 1'b1;
            busy_q    <= (nxt_state != ST_IDLE);
            done_q    <= done_c;
            dout_q    <= dout_c;
        end
    end

    // Latch the code word on an accepted start; the shift register is
    // always fed from this copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            code_q <= '0;
        else if (state == ST_IDLE && bus.start)
            code_q <= bus.code;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dout      = dout_q;
    assign bus.sr_op     = sr_op_c;
    assign bus.sr_d      = code_q;
    assign bus.sr_pt_bit = 2'b00;
endmodule

// File: tb/tb_pt2262_tx_ctrl.sv
// Bench for pt2262_tx_ctrl: three instances (alpha 1 / 1 frame, alpha 1 /
// 4 frames, alpha 3 / 2 frames) share stimulus; each has its own shift
// register model. Every cycle is compared against a cycle-indexed model.
module tb_pt2262_tx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] code = '0;
    logic [23:0] sr_a, sr_b, sr_c;
    int          nvec = 0;
    int          nmis = 0;
    int          cur = 0;

    typedef struct packed {
        logic       dout;
        logic       busy;
        logic       done;
        logic [2:0] op;
        logic [1:0] trit;
        logic       in_trit;
    } exp_t;

    always #5 clk = ~clk;

    pt2262_tx_ctrl_if #(.TRITS(12)) if_a();
    pt2262_tx_ctrl_if #(.TRITS(12)) if_b();
    pt2262_tx_ctrl_if #(.TRITS(12)) if_c();

    assign if_a.start = start;  assign if_a.stop = stop;  assign if_a.code = code;  assign if_a.sr_q = sr_a;
    assign if_b.start = start;  assign if_b.stop = stop;  assign if_b.code = code;  assign if_b.sr_q = sr_b;
    assign if_c.start = start;  assign if_c.stop = stop;  assign if_c.code = code;  assign if_c.sr_q = sr_c;

    pt2262_tx_ctrl #(.TRITS(12), .ALPHA_CYC(1), .REPEAT(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    pt2262_tx_ctrl #(.TRITS(12), .ALPHA_CYC(1), .REPEAT(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    pt2262_tx_ctrl #(.TRITS(12), .ALPHA_CYC(3), .REPEAT(2)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    // Shift register models
    always @(posedge clk) begin
        case (if_a.sr_op)
            3'b011:  sr_a <= if_a.sr_d;
            3'b100:  sr_a <= {sr_a[21:0], if_a.sr_pt_bit};
            default: sr_a <= sr_a;
        endcase
        case (if_b.sr_op)
            3'b011:  sr_b <= if_b.sr_d;
            3'b100:  sr_b <= {sr_b[21:0], if_b.sr_pt_bit};
            default: sr_b <= sr_b;
        endcase
        case (if_c.sr_op)
            3'b011:  sr_c <= if_c.sr_d;
            3'b100:  sr_c <= {sr_c[21:0], if_c.sr_pt_bit};
            default: sr_c <= sr_c;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cur, got, exp);
        end
    endtask

    // Trit waveform as four pulse segments (high, low, high, low) in alpha.
    function automatic logic trit_wave(input logic [1:0] tr, input int ai);
        int seg[4];
        int acc;
        logic lvl;
        case (tr)
            2'b00:   seg = '{4, 12, 4, 12};
            2'b11:   seg = '{12, 4, 12, 4};
            default: seg = '{4, 12, 12, 4};
        endcase
        acc = 0;
        lvl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ai >= acc && ai < acc + seg[i]) lvl = (i % 2 == 0);
            acc += seg[i];
        end
        return lvl;
    endfunction

    // Expected outputs in cycle n after start was sampled at edge 0.
    function automatic exp_t model(input int n, input int alpha, input int rep,
                                   input int stop_at, input logic [23:0] c);
        exp_t e;
        int fl, nf, last, p, f, a, ph, t, ai, si, idx;
        e = '0;
        fl = 512 * alpha;
        nf = rep;
        if (stop_at > 0) begin
            idx = (stop_at < 2) ? 0 : (stop_at - 2) / fl;
            if (idx + 1 < nf) nf = idx + 1;
        end
        last = 1 + nf * fl;
        if (n == 1) begin
            e.busy = 1'b1;
            e.op   = 3'b011;
        end else if (n >= 2 && n <= last) begin
            e.busy = 1'b1;
            p  = (n - 2) % fl;
            f  = (n - 2) / fl;
            a  = p / alpha;
            ph = p % alpha;
            if (a < 384) begin
                t  = a / 32;
                ai = a % 32;
                e.in_trit = 1'b1;
                e.trit    = c[23 - 2*t -: 2];
                e.dout    = trit_wave(e.trit, ai);
                if (ai == 31 && ph == alpha - 1) e.op = 3'b100;
            end else begin
                si = a - 384;
                e.dout = (si < 4);
                if (si == 127 && ph == alpha - 1 && f < nf - 1) e.op = 3'b011;
            end
        end else if (n == last + 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input logic dout, input logic busy,
                             input logic done, input logic [2:0] op, input exp_t e);
        check({nm, "_dout"}, dout, e.dout);
        check({nm, "_busy"}, busy, e.busy);
        check({nm, "_done"}, done, e.done);
        check({nm, "_sr_op"}, op, e.op);
    endtask

    task automatic run(input logic [23:0] c, input int stop_at, input int chg_at,
                       input logic [23:0] c2, input int rst_at, input int ncyc);
        exp_t ea;
        @(negedge clk);
        code  = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            cur = n;
            ea = model(n, 1, 1, stop_at, c);
            check_dut("a", if_a.dout, if_a.busy, if_a.done, if_a.sr_op, ea);
            check_dut("b", if_b.dout, if_b.busy, if_b.done, if_b.sr_op, model(n, 1, 4, stop_at, c));
            check_dut("c", if_c.dout, if_c.busy, if_c.done, if_c.sr_op, model(n, 3, 2, stop_at, c));
            check("a_sr_d", if_a.sr_d, c);
            if (ea.in_trit) check("a_msb", sr_a[23:22], ea.trit);
            // Hand-picked points from the all-'0' single frame
            if (c == 24'h0) begin
                if (n == 5)   check("a_hi5", if_a.dout, 1);
                if (n == 6)   check("a_lo6", if_a.dout, 0);
                if (n == 18)  check("a_hi18", if_a.dout, 1);
                if (n == 22)  check("a_lo22", if_a.dout, 0);
                if (n == 389) check("a_sync389", if_a.dout, 1);
                if (n == 390) check("a_sync390", if_a.dout, 0);
            end
            if (stop_at == 0 && rst_at == 0) begin
                if (n == 33 || n == 385) check("a_shift", if_a.sr_op, 3'b100);
                if (n == 514)  check("a_done514", {if_a.busy, if_a.done}, 2'b01);
                if (n == 513 || n == 1025 || n == 1537) check("b_reload", if_b.sr_op, 3'b011);
                if (n == 2050) check("b_done2050", {if_b.busy, if_b.done}, 2'b01);
            end
            if (stop_at == 700 && n == 1026) check("b_stopdone", if_b.done, 1);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_a", {if_a.dout, if_a.busy, if_a.done, if_a.sr_op}, 6'b0);
                check("rst_b", {if_b.dout, if_b.busy, if_b.done, if_b.sr_op}, 6'b0);
                check("rst_c", {if_c.dout, if_c.busy, if_c.done, if_c.sr_op}, 6'b0);
                break;
            end
            stop  = (n == stop_at);
            start = (n == chg_at);
            if (n == chg_at) code = c2;
        end
        start = 1'b0;
        stop  = 1'b0;
        if (!rst_n) begin
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {if_a.dout, if_a.busy, if_a.done, if_a.sr_op, if_a.sr_pt_bit}, 8'b0);
        check("reset_b", {if_b.dout, if_b.busy, if_b.done, if_b.sr_op}, 6'b0);
        check("reset_c", {if_c.dout, if_c.busy, if_c.done, if_c.sr_op}, 6'b0);
        check("reset_sr_d", if_a.sr_d, 24'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(24'h000000, 0,   0,   24'h0,      0,   3080);  // all '0'
        run(24'hFFFFFF, 0,   0,   24'h0,      0,   3080);  // all '1'
        run(24'h5A0F00, 0,   0,   24'h0,      0,   3080);  // mixed trits
        run(24'hC3A596, 700, 0,   24'h0,      0,   3080);  // stop at cycle 700
        run(24'h123456, 0,   100, 24'hABCDEF, 0,   3080);  // start/code change while busy
        run(24'h9C63F0, 0,   0,   24'h0,      300, 3080);  // async reset mid-trit
        run(24'h6B1E47, 0,   0,   24'h0,      0,   3080);  // clean frame after reset

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
